// File: rtl/coin_payout.sv
// Coin payout controller: pays a requested amount using the largest coin in
// stock, one coin at a time, with a per-coin hopper acknowledge timeout.
module coin_payout #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] amount,
  input  logic       half_dollar_s,
  input  logic       quarter_s,
  input  logic       dime_s,
  input  logic       nickel_s,
  input  logic       hopper_ack,
  output logic [3:0] eject,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       jam,
  output logic [7:0] remaining,
  output logic [4:0] half_dollar_out,
  output logic [4:0] quarter_out,
  output logic [4:0] dime_out,
  output logic [4:0] nickel_out
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    RELEASE,
    DONE
  } state_t;

  // Counter value at which the next unacknowledged cycle is a timeout.
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [4:0] COUNT_MAX = 5'd31;

  state_t           state_q, state_d;
  logic [3:0]       eject_d;
  logic             busy_d, done_d, short_d, jam_d;
  logic [7:0]       rem_d;
  logic [7:0]       tcnt_q, tcnt_d;
  // Index 3 = 50c, 2 = 25c, 1 = 10c, 0 = 5c, matching the eject bit order.
  logic [3:0][4:0]  cnt_q, cnt_d;

  // Value in cents of the coin currently being ejected.
  function automatic logic [7:0] coin_value(input logic [3:0] e);
    case (e)
      4'b1000: coin_value = 8'd50;
      4'b0100: coin_value = 8'd25;
      4'b0010: coin_value = 8'd10;
      4'b0001: coin_value = 8'd5;
      default: coin_value = 8'd0;
    endcase
  endfunction

  // Next-state and next-output logic for the payout sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d = state_q;
    eject_d = eject;
    busy_d  = busy;
    done_d  = 1'b0;
    short_d = short;
    jam_d   = jam;
    rem_d   = remaining;
    tcnt_d  = tcnt_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          rem_d   = amount;
          busy_d  = 1'b1;
          short_d = 1'b0;
          jam_d   = 1'b0;
          cnt_d   = '0;
          state_d = SELECT;
        end
      end

      SELECT: begin
        tcnt_d = '0;
        if (remaining == 8'd0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (half_dollar_s && remaining >= 8'd50) begin
          eject_d = 4'b1000;
          state_d = EJECT;
        end else if (quarter_s && remaining >= 8'd25) begin
          eject_d = 4'b0100;
          state_d = EJECT;
        end else if (dime_s && remaining >= 8'd10) begin
          eject_d = 4'b0010;
          state_d = EJECT;
        end else if (nickel_s && remaining >= 8'd5) begin
          eject_d = 4'b0001;
          state_d = EJECT;
        end else begin
          // Something is still owed but no coin in stock fits it.
          short_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      EJECT: begin
        if (hopper_ack) begin
          eject_d = '0;
          // The eject register, not the live stock bits, identifies the coin.
          if (coin_value(eject) <= remaining) begin
            rem_d = remaining - coin_value(eject);
          end
          for (int i = 0; i < 4; i++) begin
            if (eject[i] && cnt_q[i] != COUNT_MAX) begin
              cnt_d[i] = cnt_q[i] + 5'd1;
            end
          end
          state_d = RELEASE;
        end else if (tcnt_q == TMO_LAST) begin
          tcnt_d  = tcnt_q + 8'd1;
          eject_d = '0;
          jam_d   = 1'b1;
          short_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      RELEASE: begin
        // Hopper must drop its acknowledge before the next coin is chosen.
        if (!hopper_ack) begin
          state_d = SELECT;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, even mid-eject.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      eject     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      jam       <= 1'b0;
      remaining <= '0;
      tcnt_q    <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge.
      state_q   <= state_d;
      eject     <= eject_d;
      busy      <= busy_d;
      done      <= done_d;
      short     <= short_d;
      jam       <= jam_d;
      remaining <= rem_d;
      tcnt_q    <= tcnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign half_dollar_out = cnt_q[3];
  assign quarter_out     = cnt_q[2];
  assign dime_out        = cnt_q[1];
  assign nickel_out      = cnt_q[0];

endmodule

// File: tb/tb_coin_payout.sv
// Directed bench for coin_payout: expected ejects and final payout results are
// queued when each request is issued and compared as the DUT produces them.
module tb_coin_payout;

  localparam int unsigned TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [7:0] amount = '0;
  logic       half_dollar_s = 1'b1;
  logic       quarter_s = 1'b1;
  logic       dime_s = 1'b1;
  logic       nickel_s = 1'b1;
  logic       hopper_ack = 1'b0;
  logic [3:0] eject;
  logic       busy, done, short, jam;
  logic [7:0] remaining;
  logic [4:0] half_dollar_out, quarter_out, dime_out, nickel_out;

  typedef struct {
    logic [7:0] rem;
    logic [4:0] h, q, d, n;
    logic       short_f;
    logic       jam_f;
  } result_t;

  logic [3:0] exp_ej_q[$];
  result_t    exp_res_q[$];
  int         checks = 0;
  int         errors = 0;

  coin_payout #(.TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .amount          (amount),
    .half_dollar_s   (half_dollar_s),
    .quarter_s       (quarter_s),
    .dime_s          (dime_s),
    .nickel_s        (nickel_s),
    .hopper_ack      (hopper_ack),
    .eject           (eject),
    .busy            (busy),
    .done            (done),
    .short           (short),
    .jam             (jam),
    .remaining       (remaining),
    .half_dollar_out (half_dollar_out),
    .quarter_out     (quarter_out),
    .dime_out        (dime_out),
    .nickel_out      (nickel_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_stock(input logic [3:0] s);
    {half_dollar_s, quarter_s, dime_s, nickel_s} = s;
  endtask

  task automatic expect_coins(input logic [3:0] e, input int n);
    repeat (n) exp_ej_q.push_back(e);
  endtask

  task automatic expect_result(input logic [7:0] rem, input logic [4:0] h, input logic [4:0] q,
                               input logic [4:0] d, input logic [4:0] n,
                               input logic sh, input logic jm);
    result_t r;
    r.rem = rem; r.h = h; r.q = q; r.d = d; r.n = n; r.short_f = sh; r.jam_f = jm;
    exp_res_q.push_back(r);
  endtask

  // Pulse req for one edge and confirm it was accepted.
  task automatic start(input logic [7:0] a);
    @(negedge clk);
    req = 1'b1;
    amount = a;
    @(negedge clk);
    req = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
  endtask

  // Act as the hopper until the done pulse, then compare the final result.
  task automatic serve(input int ack_delay, input bit stuck);
    int         cyc;
    int         high;
    bit         fin;
    logic [3:0] e;
    result_t    r;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      if (cyc > 5000) begin
        check("watchdog_done", {31'd0, done}, 32'd1);
        fin = 1'b1;
      end else if (done) begin
        if (exp_res_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          r = exp_res_q.pop_front();
          check("remaining",       {24'd0, remaining},       {24'd0, r.rem});
          check("half_dollar_out", {27'd0, half_dollar_out}, {27'd0, r.h});
          check("quarter_out",     {27'd0, quarter_out},     {27'd0, r.q});
          check("dime_out",        {27'd0, dime_out},        {27'd0, r.d});
          check("nickel_out",      {27'd0, nickel_out},      {27'd0, r.n});
          check("short",           {31'd0, short},           {31'd0, r.short_f});
          check("jam",             {31'd0, jam},             {31'd0, r.jam_f});
          check("coins_left",      exp_ej_q.size(),          32'd0);
          @(negedge clk);
          check("done_pulse_end",  {31'd0, done},            32'd0);
          check("busy_clear",      {31'd0, busy},            32'd0);
          check("short_held",      {31'd0, short},           {31'd0, r.short_f});
        end
        fin = 1'b1;
      end else if (eject != 4'b0000) begin
        if (exp_ej_q.size() == 0) begin
          check("unexpected_eject", {28'd0, eject}, 32'd0);
          e = 4'b0000;
        end else begin
          e = exp_ej_q.pop_front();
          check("eject_order", {28'd0, eject}, {28'd0, e});
        end
        if (stuck) begin
          high = 0;
          while (eject != 4'b0000 && high < int'(TIMEOUT) + 10) begin
            high++;
            @(negedge clk);
          end
          check("eject_cycles", high, TIMEOUT);
          check("timeout_done", {31'd0, done}, 32'd1);
        end else begin
          repeat (ack_delay - 1) @(negedge clk);
          hopper_ack = 1'b1;
          @(negedge clk);
          check("ack_clears_eject", {28'd0, eject}, 32'd0);
          hopper_ack = 1'b0;
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_eject",     {28'd0, eject},     32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_remaining", {24'd0, remaining}, 32'd0);
    rst = 1'b1;

    // 40c with everything in stock: 25, 10, 5
    set_stock(4'b1111);
    expect_coins(4'b0100, 1);
    expect_coins(4'b0010, 1);
    expect_coins(4'b0001, 1);
    expect_result(8'd0, 5'd0, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0);
    start(8'd40);
    serve(2, 1'b0);

    // 100c with no half dollars: four quarters
    set_stock(4'b0111);
    expect_coins(4'b0100, 4);
    expect_result(8'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
    start(8'd100);
    serve(2, 1'b0);

    // 15c with no nickels: one dime, 5c short
    set_stock(4'b1110);
    expect_coins(4'b0010, 1);
    expect_result(8'd5, 5'd0, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0);
    start(8'd15);
    serve(2, 1'b0);

    // 25c with the hopper never acknowledging: jam after TIMEOUT cycles
    set_stock(4'b1111);
    expect_coins(4'b0100, 1);
    expect_result(8'd25, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    start(8'd25);
    serve(1, 1'b1);

    // 255c in nickels only: 51 coins, count saturates at 31
    set_stock(4'b0001);
    expect_coins(4'b0001, 51);
    expect_result(8'd0, 5'd0, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0);
    start(8'd255);
    serve(1, 1'b0);

    // Reset asserted while a coin is being ejected
    set_stock(4'b1111);
    start(8'd40);
    @(negedge clk);
    check("pre_rst_eject", {28'd0, eject}, 32'h4);
    #2 rst = 1'b0;
    #1;
    check("async_rst_eject",     {28'd0, eject},     32'd0);
    check("async_rst_busy",      {31'd0, busy},      32'd0);
    check("async_rst_remaining", {24'd0, remaining}, 32'd0);

    // First req after reset release is accepted; 0c finishes two edges later
    @(negedge clk);
    rst = 1'b1;
    req = 1'b1;
    amount = 8'd0;
    @(negedge clk);
    check("zero_accept_busy", {31'd0, busy}, 32'd1);
    check("zero_no_done_yet", {31'd0, done}, 32'd0);
    amount = 8'd50;  // req still high while busy: must be ignored
    @(negedge clk);
    req = 1'b0;
    check("zero_done",  {31'd0, done},  32'd1);
    check("zero_eject", {28'd0, eject}, 32'd0);
    check("zero_short", {31'd0, short}, 32'd0);
    @(negedge clk);
    check("zero_done_end",    {31'd0, done},      32'd0);
    check("zero_idle",        {31'd0, busy},      32'd0);
    check("busy_req_ignored", {24'd0, remaining}, 32'd0);
    repeat (3) @(negedge clk);
    check("still_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_payout.md
COIN_PAYOUT -- requirements
Module: coin_payout

Interface
REQ-001 SHALL have parameter: TIMEOUT, 200, max cycles to wait for hopper_ack per coin (1..255).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  payout request, sampled in IDLE only.
- amount  in  8  cents to pay, latched on accepted req.
- half_dollar_s, quarter_s, dime_s, nickel_s  in  1 each  hopper stock available.
- hopper_ack  in  1  hopper coin-sensed handshake.
- eject  out  4  one-hot eject command; bit3 = 50c, bit2 = 25c, bit1 = 10c, bit0 = 5c.
- busy  out  1  payout in progress.
- done  out  1  one-cycle completion pulse.
- short  out  1  amount not fully paid; valid with done, held until next accepted req.
- jam  out  1  hopper timeout occurred; held until next accepted req.
- remaining  out  8  cents still owed.
- half_dollar_out, quarter_out, dime_out, nickel_out  out  5 each  coins paid this payout.

Function
REQ-003 SHALL implement states IDLE, SELECT, EJECT, RELEASE, DONE; all outputs registered.
REQ-004 IDLE with req=1 at edge k: SHALL set remaining=amount, busy=1, clear all coin counts and short and jam, and enter SELECT at k.
REQ-005 SHALL ignore req in any state other than IDLE.
REQ-006 SELECT SHALL choose the largest denomination whose stock bit is 1 and whose value is <= remaining, in the order 50, 25, 10, 5; it SHALL then set the matching eject bit, clear the timeout counter and enter EJECT on the next edge.
REQ-007 SELECT with remaining=0 SHALL enter DONE with short=0.
REQ-008 SELECT with remaining>0 and no eligible denomination (out of stock, or remainder <5) SHALL enter DONE with short=1.
REQ-009 In EJECT, hopper_ack sampled 1 SHALL:
- clear eject;
- subtract the coin value from remaining;
- increment that denomination's count;
- enter RELEASE.
REQ-010 In EJECT, each cycle without ack SHALL increment the timeout counter. When the counter reaches TIMEOUT, the block SHALL clear eject, set jam=1 and short=1, leave remaining unchanged, and enter DONE.
REQ-011 RELEASE SHALL wait for hopper_ack sampled 0, then enter SELECT. RELEASE has no timeout.
REQ-012 Entering DONE SHALL set done=1. On the following edge the block SHALL set done=0 and busy=0 and enter IDLE.
REQ-013 At most one eject bit SHALL be high at any time, and eject SHALL be 0 outside EJECT.
REQ-014 Coin counts SHALL saturate at 31.
REQ-015 remaining SHALL never underflow; subtraction occurs only for a coin whose value is <= remaining.
REQ-016 Stock bits SHALL be sampled only in SELECT; a stock change during EJECT has no effect on the coin in flight.
REQ-017 amount=0 SHALL produce done two edges after acceptance, with no eject.

Reset
REQ-018 rst=0 SHALL immediately force IDLE and set eject, busy, done, short, jam, remaining, all counts and the timeout counter to 0, regardless of state, including mid-EJECT.
REQ-019 After rst deasserts, the first req SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- amount=40, all stock=1, ack 2 cycles after each eject -> ejects 25, 10, 5 in that order; counts q=1, d=1, n=1; remaining=0; done pulse; short=0.
- amount=100, half_dollar_s=0 -> four 25c ejects; quarter_out=4; short=0.
- amount=15, nickel_s=0 -> one 10c eject; remaining=5; short=1; done pulse.
- amount=25, hopper_ack held 0 -> eject=4'b0100 for TIMEOUT cycles, then eject=0, jam=1, short=1, remaining=25, done pulse.
- rst=0 asserted while in EJECT -> eject, busy and remaining = 0 immediately, with no clock edge needed.
- amount=0 -> done two edges after req with no eject; a second req asserted while busy is ignored.
